// File: rtl/mm_pkg.sv
// Shared types and helpers for the matrix-engine tiling sequencer.
package mm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ISSUE,
        ST_DONE
    } mm_state_t;

    // Integer log2, used to derive the tile shift amount from N.
    function automatic int unsigned log2_of(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned v = n; v > 1; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mm_tile_controller_issuer.sv
// One instruction stream: walks W inner tiles O times, presenting each on a
// registered valid/ready port with the address stepping by a fixed stride.
module instruction_issuer #(
    parameter int unsigned ADDRESS_BITS = 64,
    parameter int unsigned LENGTH_BITS  = 13,
    parameter int unsigned COUNT_BITS   = 11
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [ADDRESS_BITS-1:0] base,
    input  logic [ADDRESS_BITS-1:0] stride,
    input  logic [LENGTH_BITS-1:0]  length,
    input  logic [COUNT_BITS-1:0]   repeats,
    input  logic [COUNT_BITS-1:0]   wrap_count,
    input  logic [COUNT_BITS-1:0]   outer_count,
    output logic                    instruction_valid,
    input  logic                    instruction_ready,
    output logic [ADDRESS_BITS-1:0] inst_address,
    output logic [LENGTH_BITS-1:0]  inst_length,
    output logic [COUNT_BITS-1:0]   inst_repeats,
    output logic                    finished,
    output logic                    last_fire
);

    localparam logic [COUNT_BITS-1:0] ONE = COUNT_BITS'(1);

    logic [ADDRESS_BITS-1:0] base_q;
    logic [ADDRESS_BITS-1:0] stride_q;
    logic [COUNT_BITS-1:0]   wrap_q;
    logic [COUNT_BITS-1:0]   outer_count_q;
    logic [COUNT_BITS-1:0]   inner_q;
    logic [COUNT_BITS-1:0]   outer_q;

    logic fire;
    logic inner_last;
    logic outer_last;

    assign fire       = instruction_valid && instruction_ready;
    assign inner_last = (inner_q == (wrap_q - ONE));
    assign outer_last = (outer_q == (outer_count_q - ONE));
    assign last_fire  = fire && inner_last && outer_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base_q            <= '0;
            stride_q          <= '0;
            wrap_q            <= '0;
            outer_count_q     <= '0;
            inner_q           <= '0;
            outer_q           <= '0;
            instruction_valid <= 1'b0;
            inst_address      <= '0;
            inst_length       <= '0;
            inst_repeats      <= '0;
            finished          <= 1'b0;
        end else if (start) begin
            base_q            <= base;
            stride_q          <= stride;
            wrap_q            <= wrap_count;
            outer_count_q     <= outer_count;
            inner_q           <= '0;
            outer_q           <= '0;
            instruction_valid <= 1'b1;
            inst_address      <= base;
            inst_length       <= length;
            inst_repeats      <= repeats;
            finished          <= 1'b0;
        end else if (fire) begin
            if (inner_last) begin
                // Address rewinds to base at every inner wrap.
                inner_q      <= '0;
                inst_address <= base_q;
                if (outer_last) begin
                    instruction_valid <= 1'b0;
                    finished          <= 1'b1;
                end else begin
                    outer_q <= outer_q + ONE;
                end
            end else begin
                inner_q      <= inner_q + ONE;
                inst_address <= inst_address + stride_q;
            end
        end
    end

endmodule

// File: rtl/mm_tile_controller.sv
// Tiling sequencer: splits C = A*B into NxN output tiles and drives the
// A-side and B-side memory_buffer instruction ports.
module mm_tile_controller
    import mm_pkg::*;
#(
    parameter int unsigned N                    = 4,
    parameter int unsigned MEMORY_ADDRESS_BITS  = 64,
    parameter int unsigned MAX_MATRIX_LENGTH    = 4096,
    parameter int unsigned COUNTER_BITS         = $clog2(MAX_MATRIX_LENGTH + 1),
    parameter int unsigned REPEATS_COUNTER_BITS = $clog2(MAX_MATRIX_LENGTH / N + 1)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            job_valid,
    output logic                            job_ready,
    input  logic [MEMORY_ADDRESS_BITS-1:0]  job_a_address,
    input  logic [MEMORY_ADDRESS_BITS-1:0]  job_b_address,
    input  logic [COUNTER_BITS-1:0]         job_rows,
    input  logic [COUNTER_BITS-1:0]         job_cols,
    input  logic [COUNTER_BITS-1:0]         job_length,
    output logic                            a_instruction_valid,
    input  logic                            a_instruction_ready,
    output logic [MEMORY_ADDRESS_BITS-1:0]  a_address,
    output logic [COUNTER_BITS-1:0]         a_length,
    output logic [REPEATS_COUNTER_BITS-1:0] a_repeats,
    output logic                            b_instruction_valid,
    input  logic                            b_instruction_ready,
    output logic [MEMORY_ADDRESS_BITS-1:0]  b_address,
    output logic [COUNTER_BITS-1:0]         b_length,
    output logic [REPEATS_COUNTER_BITS-1:0] b_repeats,
    output logic                            job_done
);

    localparam int unsigned LOG2_N = log2_of(N);

    generate
        if (N == 0 || (N & (N - 1)) != 0) begin : g_n_check
            $error("mm_tile_controller: N must be a power of two");
        end
    endgenerate

    mm_state_t state_q, state_d;

    logic [MEMORY_ADDRESS_BITS-1:0]  a_base_q, b_base_q;
    logic [COUNTER_BITS-1:0]         rows_q, cols_q, length_q;

    logic [REPEATS_COUNTER_BITS-1:0] tiles_r, tiles_c;
    logic [MEMORY_ADDRESS_BITS-1:0]  stride;
    logic                            zero_job;
    logic                            start;

    logic a_finished, a_last_fire;
    logic b_finished, b_last_fire;

    assign tiles_r  = REPEATS_COUNTER_BITS'(rows_q >> LOG2_N);
    assign tiles_c  = REPEATS_COUNTER_BITS'(cols_q >> LOG2_N);
    assign stride   = MEMORY_ADDRESS_BITS'(length_q) << LOG2_N;
    assign zero_job = (tiles_r == '0) || (tiles_c == '0) || (length_q == '0);

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (job_valid) begin
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (zero_job) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ISSUE;
                    start   = 1'b1;
                end
            end
            ST_ISSUE: begin
                // Leave on the edge of the final handshake so job_done lines up with it.
                if ((a_finished || a_last_fire) && (b_finished || b_last_fire)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            job_ready <= 1'b1;
            job_done  <= 1'b0;
            a_base_q  <= '0;
            b_base_q  <= '0;
            rows_q    <= '0;
            cols_q    <= '0;
            length_q  <= '0;
        end else begin
            state_q   <= state_d;
            job_ready <= (state_d == ST_IDLE);
            job_done  <= (state_d == ST_DONE);
            if (state_q == ST_IDLE && job_valid) begin
                a_base_q <= job_a_address;
                b_base_q <= job_b_address;
                rows_q   <= job_rows;
                cols_q   <= job_cols;
                length_q <= job_length;
            end
        end
    end

    instruction_issuer #(
        .ADDRESS_BITS (MEMORY_ADDRESS_BITS),
        .LENGTH_BITS  (COUNTER_BITS),
        .COUNT_BITS   (REPEATS_COUNTER_BITS)
    ) u_a_issuer (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .base              (a_base_q),
        .stride            (stride),
        .length            (length_q),
        .repeats           (tiles_c),
        .wrap_count        (tiles_r),
        .outer_count       (REPEATS_COUNTER_BITS'(1)),
        .instruction_valid (a_instruction_valid),
        .instruction_ready (a_instruction_ready),
        .inst_address      (a_address),
        .inst_length       (a_length),
        .inst_repeats      (a_repeats),
        .finished          (a_finished),
        .last_fire         (a_last_fire)
    );

    instruction_issuer #(
        .ADDRESS_BITS (MEMORY_ADDRESS_BITS),
        .LENGTH_BITS  (COUNTER_BITS),
        .COUNT_BITS   (REPEATS_COUNTER_BITS)
    ) u_b_issuer (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .base              (b_base_q),
        .stride            (stride),
        .length            (length_q),
        .repeats           (REPEATS_COUNTER_BITS'(1)),
        .wrap_count        (tiles_c),
        .outer_count       (tiles_r),
        .instruction_valid (b_instruction_valid),
        .instruction_ready (b_instruction_ready),
        .inst_address      (b_address),
        .inst_length       (b_length),
        .inst_repeats      (b_repeats),
        .finished          (b_finished),
        .last_fire         (b_last_fire)
    );

endmodule

// File: tb/tb_mm_tile_controller.sv
// Self-checking bench for mm_tile_controller against a queue-based tile model.
module tb_mm_tile_controller;

    localparam int AW = 64;
    localparam int CB = 13;
    localparam int RB = 11;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [CB-1:0] len;
        logic [RB-1:0] rep;
    } instr_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          job_valid;
    logic          job_ready;
    logic [AW-1:0] job_a_address, job_b_address;
    logic [CB-1:0] job_rows, job_cols, job_length;
    logic          a_instruction_valid, a_instruction_ready;
    logic [AW-1:0] a_address;
    logic [CB-1:0] a_length;
    logic [RB-1:0] a_repeats;
    logic          b_instruction_valid, b_instruction_ready;
    logic [AW-1:0] b_address;
    logic [CB-1:0] b_length;
    logic [RB-1:0] b_repeats;
    logic          job_done;

    int checks = 0;
    int errors = 0;

    instr_t exp_a[$];
    instr_t exp_b[$];

    always #5 clk = ~clk;

    mm_tile_controller #(
        .N                   (4),
        .MEMORY_ADDRESS_BITS (AW),
        .MAX_MATRIX_LENGTH   (4096)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .job_valid           (job_valid),
        .job_ready           (job_ready),
        .job_a_address       (job_a_address),
        .job_b_address       (job_b_address),
        .job_rows            (job_rows),
        .job_cols            (job_cols),
        .job_length          (job_length),
        .a_instruction_valid (a_instruction_valid),
        .a_instruction_ready (a_instruction_ready),
        .a_address           (a_address),
        .a_length            (a_length),
        .a_repeats           (a_repeats),
        .b_instruction_valid (b_instruction_valid),
        .b_instruction_ready (b_instruction_ready),
        .b_address           (b_address),
        .b_length            (b_length),
        .b_repeats           (b_repeats),
        .job_done            (job_done)
    );

    // Reference: A tile i once with repeats = C; B tile j for every (i, j).
    task automatic build_expected(input logic [AW-1:0] a, input logic [AW-1:0] b,
                                  input int rows, input int cols, input int len);
        int r, c;
        logic [AW-1:0] s;
        instr_t t;
        exp_a.delete();
        exp_b.delete();
        r = rows / 4;
        c = cols / 4;
        s = AW'(len) * AW'(4);
        if (len != 0 && r != 0 && c != 0) begin
            for (int i = 0; i < r; i++) begin
                t.addr = a + AW'(i) * s;
                t.len  = CB'(len);
                t.rep  = RB'(c);
                exp_a.push_back(t);
            end
            for (int i = 0; i < r; i++) begin
                for (int j = 0; j < c; j++) begin
                    t.addr = b + AW'(j) * s;
                    t.len  = CB'(len);
                    t.rep  = RB'(1);
                    exp_b.push_back(t);
                end
            end
        end
    endtask

    task automatic start_job(input logic [AW-1:0] a, input logic [AW-1:0] b,
                             input int rows, input int cols, input int len, input bit hold);
        bit ok;
        job_a_address = a;
        job_b_address = b;
        job_rows      = CB'(rows);
        job_cols      = CB'(cols);
        job_length    = CB'(len);
        job_valid     = 1'b1;
        build_expected(a, b, rows, cols, len);
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (job_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL start_job: job_ready=%b after 100 cycles, required 1", job_ready);
        end
        @(posedge clk);
        #1;
        if (!hold) job_valid = 1'b0;
    endtask

    // Cycle-by-cycle checking of one accepted job; starts just after the acceptance edge.
    task automatic check_job(input string name, input bit rand_a, input bit rand_b,
                             output int a_hs, output int b_hs);
        bit     zero, a_st, b_st, ended;
        int     done_cyc, last_hs;
        instr_t a_now, b_now, a_sv, b_sv, e;
        zero     = (exp_a.size() == 0) && (exp_b.size() == 0);
        a_st     = 1'b0;
        b_st     = 1'b0;
        ended    = 1'b0;
        done_cyc = -1;
        last_hs  = -1;
        a_hs     = 0;
        b_hs     = 0;
        a_sv     = '0;
        b_sv     = '0;
        a_instruction_ready = rand_a ? 1'($urandom_range(0, 1)) : 1'b1;
        b_instruction_ready = rand_b ? 1'($urandom_range(0, 1)) : 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            a_now = {a_address, a_length, a_repeats};
            b_now = {b_address, b_length, b_repeats};
            if (done_cyc >= 0) begin
                checks++;
                if (job_done !== 1'b0 || job_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL %s after_done: job_done=%b job_ready=%b, required 0 1", name, job_done, job_ready);
                end
                checks++;
                if (exp_a.size() != 0 || exp_b.size() != 0) begin
                    errors++;
                    $display("FAIL %s leftover: a=%0d b=%0d instructions missing, required 0 0", name, exp_a.size(), exp_b.size());
                end
                ended = 1'b1;
                break;
            end
            if (c == 0) begin
                checks++;
                if ({a_instruction_valid, b_instruction_valid, job_done, job_ready} !== 4'b0000) begin
                    errors++;
                    $display("FAIL %s setup: va=%b vb=%b done=%b ready=%b, required all 0", name,
                             a_instruction_valid, b_instruction_valid, job_done, job_ready);
                end
            end
            if (c == 1) begin
                checks++;
                if (zero ? (job_done !== 1'b1) : ({a_instruction_valid, b_instruction_valid} !== 2'b11)) begin
                    errors++;
                    $display("FAIL %s first_cycle: va=%b vb=%b done=%b, required %s", name,
                             a_instruction_valid, b_instruction_valid, job_done, zero ? "done=1" : "va=vb=1");
                end
            end
            if (zero) begin
                checks++;
                if (a_instruction_valid !== 1'b0 || b_instruction_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL %s zero_valid: va=%b vb=%b, required 0 0", name, a_instruction_valid, b_instruction_valid);
                end
            end
            if (a_st) begin
                checks++;
                if (a_instruction_valid !== 1'b1 || a_now !== a_sv) begin
                    errors++;
                    $display("FAIL %s a_stable: valid=%b fields=%h, required 1 %h", name, a_instruction_valid, a_now, a_sv);
                end
            end
            if (b_st) begin
                checks++;
                if (b_instruction_valid !== 1'b1 || b_now !== b_sv) begin
                    errors++;
                    $display("FAIL %s b_stable: valid=%b fields=%h, required 1 %h", name, b_instruction_valid, b_now, b_sv);
                end
            end
            a_st = a_instruction_valid && !a_instruction_ready;
            b_st = b_instruction_valid && !b_instruction_ready;
            a_sv = a_now;
            b_sv = b_now;
            if (a_instruction_valid === 1'b1 && a_instruction_ready) begin
                checks++;
                if (exp_a.size() == 0) begin
                    errors++;
                    $display("FAIL %s a_extra: got addr=%h len=%0d rep=%0d, required no instruction", name, a_address, a_length, a_repeats);
                end else begin
                    e = exp_a.pop_front();
                    if (a_now !== e) begin
                        errors++;
                        $display("FAIL %s a_instr%0d: got addr=%h len=%0d rep=%0d, required addr=%h len=%0d rep=%0d",
                                 name, a_hs, a_address, a_length, a_repeats, e.addr, e.len, e.rep);
                    end
                end
                a_hs++;
                last_hs = c;
            end
            if (b_instruction_valid === 1'b1 && b_instruction_ready) begin
                checks++;
                if (exp_b.size() == 0) begin
                    errors++;
                    $display("FAIL %s b_extra: got addr=%h len=%0d rep=%0d, required no instruction", name, b_address, b_length, b_repeats);
                end else begin
                    e = exp_b.pop_front();
                    if (b_now !== e) begin
                        errors++;
                        $display("FAIL %s b_instr%0d: got addr=%h len=%0d rep=%0d, required addr=%h len=%0d rep=%0d",
                                 name, b_hs, b_address, b_length, b_repeats, e.addr, e.len, e.rep);
                    end
                end
                b_hs++;
                last_hs = c;
            end
            if (job_done === 1'b1) begin
                done_cyc = c;
                checks++;
                if (!zero && last_hs != c - 1) begin
                    errors++;
                    $display("FAIL %s done_timing: last handshake cycle %0d, done cycle %0d, required done one cycle later", name, last_hs, c);
                end
            end else if (c > 0) begin
                checks++;
                if (job_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s busy_ready: job_ready=%b while busy, required 0", name, job_ready);
                end
            end
            @(posedge clk);
            #1;
            a_instruction_ready = rand_a ? 1'($urandom_range(0, 1)) : 1'b1;
            b_instruction_ready = rand_b ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        checks++;
        if (!ended) begin
            errors++;
            $display("FAIL %s timeout: job_done not seen within 3000 cycles, required a pulse", name);
        end
        a_instruction_ready = 1'b1;
        b_instruction_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        job_valid = 1'b0;
        job_a_address = '0;
        job_b_address = '0;
        job_rows = '0;
        job_cols = '0;
        job_length = '0;
        a_instruction_ready = 1'b1;
        b_instruction_ready = 1'b1;
        #12;
        checks++;
        if ({a_instruction_valid, b_instruction_valid, job_done, a_address, a_length, a_repeats,
             b_address, b_length, b_repeats} !== '0 || job_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_values: va=%b vb=%b done=%b ready=%b a=%h b=%h, required zeros and ready=1",
                     a_instruction_valid, b_instruction_valid, job_done, job_ready, a_address, b_address);
        end
        #5 reset = 1'b1;
        @(negedge clk);
        checks++;
        if (job_ready !== 1'b1 || a_instruction_valid !== 1'b0 || b_instruction_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%b va=%b vb=%b, required 1 0 0", job_ready, a_instruction_valid, b_instruction_valid);
        end
    endtask

    task automatic test_basic();
        int ah, bh;
        start_job(64'h1000, 64'h2000, 8, 8, 16, 1'b0);
        check_job("basic", 1'b0, 1'b0, ah, bh);
        checks++;
        if (ah != 2 || bh != 4) begin
            errors++;
            $display("FAIL basic_counts: a=%0d b=%0d handshakes, required 2 4", ah, bh);
        end
    endtask

    task automatic test_b_stall();
        int ah, bh;
        start_job(64'h1000, 64'h2000, 8, 8, 16, 1'b0);
        check_job("b_stall", 1'b0, 1'b1, ah, bh);
        checks++;
        if (ah != 2 || bh != 4) begin
            errors++;
            $display("FAIL b_stall_counts: a=%0d b=%0d handshakes, required 2 4", ah, bh);
        end
    endtask

    task automatic test_zero_length();
        int ah, bh;
        start_job(64'h1000, 64'h2000, 8, 8, 0, 1'b0);
        check_job("zero_len", 1'b0, 1'b0, ah, bh);
        start_job(64'h1000, 64'h2000, 3, 8, 16, 1'b0);
        check_job("zero_rows", 1'b1, 1'b1, ah, bh);
        checks++;
        if (ah != 0 || bh != 0) begin
            errors++;
            $display("FAIL zero_counts: a=%0d b=%0d handshakes, required 0 0", ah, bh);
        end
    endtask

    task automatic test_wrap();
        int ah, bh;
        start_job(64'hFFFF_FFFF_FFFF_FFC0, 64'hFFFF_FFFF_FFFF_FF80, 8, 4, 16, 1'b0);
        check_job("wrap", 1'b1, 1'b0, ah, bh);
    endtask

    task automatic test_mid_reset();
        int ah, bh, bcount;
        bit hit;
        start_job(64'h1000, 64'h2000, 8, 8, 16, 1'b0);
        a_instruction_ready = 1'b1;
        b_instruction_ready = 1'b1;
        bcount = 0;
        hit = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (b_instruction_valid === 1'b1) bcount++;
            if (bcount == 2) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL mid_reset_wait: saw %0d B handshakes, required 2", bcount);
        end
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({a_instruction_valid, b_instruction_valid, job_done, a_address, a_length, a_repeats,
             b_address, b_length, b_repeats} !== '0 || job_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: va=%b vb=%b done=%b ready=%b a=%h b=%h, required zeros and ready=1",
                     a_instruction_valid, b_instruction_valid, job_done, job_ready, a_address, b_address);
        end
        #2 reset = 1'b1;
        start_job(64'h1000, 64'h2000, 8, 8, 16, 1'b0);
        check_job("after_reset", 1'b0, 1'b0, ah, bh);
    endtask

    task automatic test_hold_valid();
        int ah, bh;
        start_job(64'h4000, 64'h8000, 4, 8, 8, 1'b1);
        // Present a different job while busy; it must wait for IDLE.
        job_a_address = 64'h9000;
        job_b_address = 64'hA000;
        job_rows      = CB'(8);
        job_cols      = CB'(4);
        job_length    = CB'(4);
        check_job("hold_first", 1'b1, 1'b1, ah, bh);
        @(posedge clk);
        #1 job_valid = 1'b0;
        build_expected(64'h9000, 64'hA000, 8, 4, 4);
        check_job("hold_second", 1'b0, 1'b0, ah, bh);
    endtask

    task automatic test_random();
        int ah, bh;
        logic [AW-1:0] a, b;
        for (int n = 0; n < 6; n++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            start_job(a, b, int'($urandom_range(0, 20)), int'($urandom_range(0, 20)),
                      int'($urandom_range(0, 40)), 1'b0);
            check_job("random", 1'b1, 1'b1, ah, bh);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_b_stall();
        test_zero_length();
        test_wrap();
        test_mid_reset();
        test_hold_valid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
